// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared next-count and terminal-count helpers for the ls counter family
package ls_pkg;

    localparam logic LS_DIR_UP   = 1'b1;
    localparam logic LS_DIR_DOWN = 1'b0;

    // Out-of-range values recover into the sequence: up goes to 0, down to MODULUS-1.
    function automatic int unsigned ls_next_count(input int unsigned q,
                                                  input int unsigned modulus,
                                                  input logic        dir_up);
        if (dir_up == LS_DIR_UP) begin
            return (q >= modulus - 1) ? 0 : q + 1;
        end
        return (q == 0 || q >= modulus) ? modulus - 1 : q - 1;
    endfunction

    function automatic logic ls_terminal(input int unsigned q,
                                         input int unsigned modulus,
                                         input logic        dir_up);
        return (dir_up == LS_DIR_UP) ? (q == modulus - 1) : (q == 0);
    endfunction

endpackage

// File: rtl/ls_counter_if.sv
// rtl/ls_counter_if.sv - control, data and carry signals of one ls_counter stage
interface ls_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             _SCLR;
    logic             _LOAD;
    logic             ENP;
    logic             ENT;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;

    modport master (output _SCLR, _LOAD, ENP, ENT, UP, D, input Q, RCO);
    modport slave  (input _SCLR, _LOAD, ENP, ENT, UP, D, output Q, RCO);
endinterface

// File: rtl/ls_counter_tc.sv
// rtl/ls_counter_tc.sv - combinational terminal-count detect with ENT-gated ripple carry
module ls_counter_tc
    import ls_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir_up,
    input  logic             i_ent,
    output logic             o_rco
);
    logic w_tc;

    assign w_tc  = ls_terminal(32'(i_q), MODULUS, i_dir_up);
    assign o_rco = i_ent & w_tc;
endmodule

// File: rtl/ls_counter.sv
// rtl/ls_counter.sv - parametrised 74LS16x-style counter with load, sync clear and carry cascade
module ls_counter
    import ls_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned UPDOWN    = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         CLK,
    input  logic         _CLR,
    ls_counter_if.slave  bus
);
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "ls_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "ls_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $fatal(1, "ls_counter: RESET_VAL must be below MODULUS");
    end
    if (UPDOWN > 1) begin : g_bad_updown
        $fatal(1, "ls_counter: UPDOWN must be 0 or 1");
    end

    logic [WIDTH-1:0] r_q;
    logic             w_dir_up;
    logic [WIDTH-1:0] w_next;
    logic             w_rco;

    assign w_dir_up = (UPDOWN == 0) ? LS_DIR_UP : bus.UP;
    assign w_next   = WIDTH'(ls_next_count(32'(r_q), MODULUS, w_dir_up));

    // Clear beats load beats count; load ignores the enables.
    always_ff @(posedge CLK or negedge _CLR) begin
        if (!_CLR) begin
            r_q <= WIDTH'(RESET_VAL);
        end else if (!bus._SCLR) begin
            r_q <= '0;
        end else if (!bus._LOAD) begin
            r_q <= bus.D;
        end else if (bus.ENP && bus.ENT) begin
            r_q <= w_next;
        end
    end

    ls_counter_tc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc (
        .i_q      (r_q),
        .i_dir_up (w_dir_up),
        .i_ent    (bus.ENT),
        .o_rco    (w_rco)
    );

    assign bus.Q   = r_q;
    assign bus.RCO = w_rco;
endmodule

// File: tb/tb_ls_counter.sv
// tb/tb_ls_counter.sv - randomized scoreboard bench for ls_counter: decade up/down stage plus 8-bit cascade
module tb_ls_counter;

    localparam int M = 10;

    logic CLK = 1'b0;
    logic clr_n;
    always #5 CLK = ~CLK;

    ls_counter_if #(.WIDTH(4)) a_if ();
    ls_counter_if #(.WIDTH(4)) lo_if ();
    ls_counter_if #(.WIDTH(4)) hi_if ();

    assign hi_if.ENT = lo_if.RCO;

    ls_counter #(.WIDTH(4), .MODULUS(10), .UPDOWN(1), .RESET_VAL(0)) u_dut (
        .CLK (CLK), ._CLR (clr_n), .bus (a_if.slave));
    ls_counter #(.WIDTH(4), .MODULUS(16), .UPDOWN(0), .RESET_VAL(0)) u_lo (
        .CLK (CLK), ._CLR (clr_n), .bus (lo_if.slave));
    ls_counter #(.WIDTH(4), .MODULUS(16), .UPDOWN(0), .RESET_VAL(0)) u_hi (
        .CLK (CLK), ._CLR (clr_n), .bus (hi_if.slave));

    typedef struct {
        int q;
        bit rco;
        int cas;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mq    = 0;
    int   mc    = 0;
    event ev_async;

    function automatic int ref_next(int q, bit up);
        if (up) return (q < M) ? (q + 1) % M : 0;
        return (q < M) ? (q + M - 1) % M : M - 1;
    endfunction

    function automatic bit ref_tc(int q, bit up);
        return up ? (q == M - 1) : (q == 0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit clr, sclr, load, enp, ent, up, input int d, input bit cen);
        @(negedge CLK);
        clr_n       = clr;
        a_if._SCLR  = sclr;
        a_if._LOAD  = load;
        a_if.ENP    = enp;
        a_if.ENT    = ent;
        a_if.UP     = up;
        a_if.D      = 4'(d);
        lo_if.ENP   = cen;
        hi_if.ENP   = cen;
        if (!clr) begin
            mq = 0;
            mc = 0;
        end else begin
            if (!sclr)            mq = 0;
            else if (!load)       mq = d;
            else if (enp && ent)  mq = ref_next(mq, up);
            if (cen)              mc = (mc + 1) % 256;
        end
        sb.push_back('{mq, ent && ref_tc(mq, up), mc});
    endtask

    task automatic async_clr();
        @(negedge CLK);
        #2;
        clr_n = 1'b0;
        mq = 0;
        mc = 0;
        sb.push_back('{0, a_if.ENT && ref_tc(0, a_if.UP), 0});
        -> ev_async;
    endtask

    task automatic count(input int n, input bit up);
        for (int i = 0; i < n; i++) step(1, 1, 1, 1, 1, up, 0, 0);
    endtask

    task automatic load(input int d, input bit up);
        step(1, 1, 0, 0, 0, up, d, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or ev_async);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",   32'(a_if.Q), 32'(e.q));
                chk("rco", 32'(a_if.RCO), 32'(e.rco));
                chk("cascade", 32'({hi_if.Q, lo_if.Q}), 32'(e.cas));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n      = 1'b0;
        a_if._SCLR = 1'b1; a_if._LOAD = 1'b1; a_if.ENP = 1'b0; a_if.ENT = 1'b0;
        a_if.UP    = 1'b1; a_if.D = '0;
        lo_if._SCLR = 1'b1; lo_if._LOAD = 1'b1; lo_if.ENP = 1'b0; lo_if.ENT = 1'b1;
        lo_if.UP    = 1'b0; lo_if.D = '0;
        hi_if._SCLR = 1'b1; hi_if._LOAD = 1'b1; hi_if.ENP = 1'b0;
        hi_if.UP    = 1'b0; hi_if.D = '0;

        // reset state, including RCO while held in clear
        step(0, 1, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0);

        // decade wrap 0..9,0 then hold at 9 with and without ENT
        count(10, 1);
        count(9, 1);
        step(1, 1, 1, 0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 1, 0, 0);
        count(1, 1);

        // async clear mid-cycle from 7, held over 3 edges, then release
        load(7, 1);
        async_clr();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1, 0, 0);
        count(2, 1);

        // priority: clear beats load; load ignores enables
        load(3, 1);
        step(1, 0, 0, 1, 1, 1, 5, 0);
        step(1, 1, 0, 0, 0, 1, 5, 0);

        // out-of-range load recovery in both directions
        load(13, 1);
        count(1, 1);
        load(13, 0);
        count(1, 0);
        load(15, 0);
        step(1, 1, 1, 1, 1, 1, 0, 0);

        // down count 2,1,0,9 with RCO at 0 gated by ENT
        load(2, 0);
        count(2, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0, 0);
        count(1, 0);

        // randomized mix of all controls
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 5) != 0,  $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,  1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // cascade: 255 counts to 0xFF, one more wraps to 0x00
        step(0, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 255; i++) step(1, 1, 1, 0, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0, 1, 0, 0);

        @(posedge CLK);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
